// File: rtl/key_deb_multi.sv
// key_deb_multi: multi-channel push-button debouncer.
// Each raw key pin passes through a two-flop synchroniser and is normalised
// so that 1 means "pressed". A shared divided tick samples all channels.
// A channel's debounced level flips only after STABLE_CNT consecutive
// ticks disagree with it. The flip produces a one-clock press or release
// strobe, registered alongside the new level.
module key_deb_multi #(
  parameter int N_KEYS     = 4,
  parameter int TICK_DIV   = 250000,
  parameter int STABLE_CNT = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_any
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(STABLE_CNT - 1);
  // A released key idles at this raw level, so the synchroniser resets to it
  // and never shows a spurious press when reset is released.
  localparam logic [N_KEYS-1:0] IDLE_RAW  = {N_KEYS{ACTIVE_LOW}};

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] s;

  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick;

  logic [CW-1:0]     cnt_q [N_KEYS];
  logic [CW-1:0]     cnt_d [N_KEYS];

  logic [N_KEYS-1:0] state_q, state_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic              any_q;

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Free-running sample divider; the tick is its terminal count.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Per-channel qualification: count disagreeing ticks, flip on the last one.
  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s[i] == state_q[i]) begin
          // Any agreeing sample restarts qualification.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_d[i]   = ~state_q[i];
          cnt_d[i]     = '0;
          press_d[i]   = ~state_q[i];
          release_d[i] = state_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Per-channel counters, debounced levels and edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Registered "any key down" flag, one cycle behind key_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |state_q;
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_any     = any_q;

endmodule

// File: tb/tb_key_deb_multi.sv
// Testbench for key_deb_multi with N_KEYS=4, TICK_DIV=4, STABLE_CNT=3,
// ACTIVE_LOW=1. A behavioural model tracks, per edge since reset release,
// which raw value each tick sees and how many consecutive disagreeing
// ticks each key has accumulated.
module tb_key_deb_multi;

  localparam int NK  = 4;
  localparam int TD  = 4;
  localparam int SC  = 3;

  logic          clk;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state, key_press, key_release;
  logic          key_any;

  int total = 0;
  int bad   = 0;

  // model state
  int            n;
  int            run [NK];
  logic [NK-1:0] k1, k2;
  logic [NK-1:0] m_state, m_press, m_rel;
  logic          m_any;

  key_deb_multi #(
    .N_KEYS(NK), .TICK_DIV(TD), .STABLE_CNT(SC), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_any(key_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mreset();
    n       = 0;
    k1      = '1;
    k2      = '1;
    m_state = '0;
    m_press = '0;
    m_rel   = '0;
    m_any   = 1'b0;
    for (int i = 0; i < NK; i++) run[i] = 0;
  endtask

  // Advance the model by one clock edge; key_in still holds the value the
  // DUT sampled at this edge. A tick sees the raw pin as it was two edges ago.
  task automatic mstep();
    logic [NK-1:0] seen;
    n++;
    seen    = ~k2;
    k2      = k1;
    k1      = key_in;
    m_any   = (m_state != '0);
    m_press = '0;
    m_rel   = '0;
    if (n % TD == 0) begin
      for (int i = 0; i < NK; i++) begin
        if (seen[i] != m_state[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == SC) begin
            run[i]     = 0;
            m_state[i] = ~m_state[i];
            if (m_state[i]) m_press[i] = 1'b1;
            else            m_rel[i]   = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag);
    total++;
    assert (key_state === m_state) else begin
      bad++; $error("FAIL %s key_state got=%b exp=%b (edge %0d)", tag, key_state, m_state, n);
    end
    total++;
    assert (key_press === m_press) else begin
      bad++; $error("FAIL %s key_press got=%b exp=%b (edge %0d)", tag, key_press, m_press, n);
    end
    total++;
    assert (key_release === m_rel) else begin
      bad++; $error("FAIL %s key_release got=%b exp=%b (edge %0d)", tag, key_release, m_rel, n);
    end
    total++;
    assert (key_any === m_any) else begin
      bad++; $error("FAIL %s key_any got=%b exp=%b (edge %0d)", tag, key_any, m_any, n);
    end
  endtask

  task automatic chk_zero(input string tag);
    total++;
    assert ({key_state, key_press, key_release, key_any} === '0) else begin
      bad++; $error("FAIL %s outputs not cleared got st=%b pr=%b rl=%b any=%b exp=0",
                    tag, key_state, key_press, key_release, key_any);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    mstep();
    #1;
    chk(tag);
  endtask

  // Assert reset wherever the caller is (may be mid-cycle), hold it across
  // two edges, release it between edges and restart the model.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    mreset();
  endtask

  initial begin
    int ch1_hits;
    int rel0;
    int both_seen;
    rst    = 1'b0;
    key_in = 4'hF;
    mreset();
    #2;
    do_reset();

    // 1. idle
    repeat (100) step("idle");

    // 2. clean press on key 0 from edge 1
    do_reset();
    key_in = 4'hE;
    repeat (11) step("press");
    total++;
    assert (key_state === 4'b0000) else begin
      bad++; $error("FAIL press_early key_state got=%b exp=%b", key_state, 4'b0000);
    end
    step("press");
    total++;
    assert (key_state === 4'b0001 && key_press === 4'b0001) else begin
      bad++; $error("FAIL press_e12 st/pr got=%b/%b exp=0001/0001", key_state, key_press);
    end
    step("press");
    total++;
    assert (key_press === 4'b0000 && key_any === 1'b1) else begin
      bad++; $error("FAIL press_e13 pr/any got=%b/%b exp=0000/1", key_press, key_any);
    end
    repeat (6) step("press_hold");

    // 3. bounce on key 1: 5-clk level runs never qualify
    ch1_hits = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) key_in[1] = ~key_in[1];
      step("bounce");
      if (key_state[1] | key_press[1] | key_release[1]) ch1_hits++;
    end
    key_in[1] = 1'b1;
    repeat (20) begin
      step("bounce_hold");
      if (key_state[1] | key_press[1] | key_release[1]) ch1_hits++;
    end
    total++;
    assert (ch1_hits === 0) else begin
      bad++; $error("FAIL bounce_ch1 activity cycles got=%0d exp=0", ch1_hits);
    end

    // 4. release key 0
    rel0 = 0;
    key_in[0] = 1'b1;
    repeat (24) begin
      step("release");
      if (key_release[0]) rel0++;
    end
    total++;
    assert (rel0 === 1) else begin
      bad++; $error("FAIL release_pulses got=%0d exp=1", rel0);
    end

    // 5. simultaneous press on keys 0 and 3
    both_seen = 0;
    key_in = 4'h6;
    repeat (20) begin
      step("simul");
      if (key_press === 4'b1001) both_seen++;
    end
    total++;
    assert (both_seen === 1 && key_state === 4'b1001) else begin
      bad++; $error("FAIL simul_press pulses=%0d st=%b exp=1/1001", both_seen, key_state);
    end

    // 6. reset mid-count with key 2 also going down
    key_in = 4'h2;
    repeat (9) step("midcount");
    #2;
    do_reset();
    repeat (11) step("requal");
    total++;
    assert (key_state === 4'b0000) else begin
      bad++; $error("FAIL requal_e11 key_state got=%b exp=0000", key_state);
    end
    step("requal");
    total++;
    assert (key_state === 4'b1101 && key_press === 4'b1101) else begin
      bad++; $error("FAIL requal_e12 st/pr got=%b/%b exp=1101/1101", key_state, key_press);
    end
    repeat (4) step("requal_hold");

    // 7. randomized per-channel activity against the model
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      int hold;
      key_in = key_in ^ NK'($urandom_range(0, 15));
      hold   = $urandom_range(1, 14);
      repeat (hold) step("rand");
    end
    repeat (20) step("rand_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
